// File: rtl/fifo_link_tx_if.sv
// FIFO-side and link-side handshake bundle for fifo_link_tx.
// slave = the transmitter, master = the environment that owns the FIFO and link receiver.
interface fifo_link_tx_if #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
);
    logic                  fifo_empty_i;
    logic [DATA_WIDTH-1:0] fifo_data_i;
    logic                  fifo_rd_en_o;
    logic [DATA_WIDTH-1:0] tx_data_o;
    logic                  tx_valid_o;
    logic                  tx_ready_i;
    logic [CNT_WIDTH-1:0]  flit_cnt_o;

    modport slave (
        input  fifo_empty_i, fifo_data_i, tx_ready_i,
        output fifo_rd_en_o, tx_data_o, tx_valid_o, flit_cnt_o
    );

    modport master (
        output fifo_empty_i, fifo_data_i, tx_ready_i,
        input  fifo_rd_en_o, tx_data_o, tx_valid_o, flit_cnt_o
    );
endinterface

// File: rtl/fifo_link_tx.sv
// Pops a registered-read FIFO into a 2-entry in-order buffer and streams it onto a
// valid/ready link, counting accepted flits.
module fifo_link_tx #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    fifo_link_tx_if.slave    bus
);
    logic [1:0][DATA_WIDTH-1:0] buf_q, buf_d;
    logic [1:0]                 occ_q, occ_d;
    logic                       pending_q, pending_d;
    logic [CNT_WIDTH-1:0]       cnt_q, cnt_d;
    logic                       xfer;
    logic                       rd_en;
    logic [2:0]                 fill_after;

    always_comb begin
        xfer       = (occ_q != 2'd0) && bus.tx_ready_i;
        // Slots already committed once this cycle's transfer leaves; an in-flight read owns one.
        fill_after = {1'b0, occ_q} + {2'b0, pending_q} - {2'b0, xfer};
        rd_en      = !rst_i && !bus.fifo_empty_i && (fill_after < 3'd2);

        buf_d     = buf_q;
        occ_d     = occ_q;
        pending_d = rd_en;
        cnt_d     = cnt_q;
        if (xfer) begin
            buf_d[0] = buf_q[1];
            occ_d    = occ_q - 2'd1;
            cnt_d    = cnt_q + 1'b1;
        end
        // After the shift occ_d is 0 or 1 whenever a read is in flight, so bit 0 picks the tail.
        if (pending_q) begin
            buf_d[occ_d[0]] = bus.fifo_data_i;
            occ_d           = occ_d + 2'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            buf_q     <= '0;
            occ_q     <= 2'd0;
            pending_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            buf_q     <= buf_d;
            occ_q     <= occ_d;
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.fifo_rd_en_o = rd_en;
    assign bus.tx_valid_o   = (occ_q != 2'd0);
    assign bus.tx_data_o    = (occ_q != 2'd0) ? buf_q[0] : '0;
    assign bus.flit_cnt_o   = cnt_q;
endmodule
